// File: rtl/regfile_pkg.sv
// Shared types for the scoreboarded register file: FSM states and the
// RISC-V ABI register aliases.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [4:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2,
        S0FP, S1, A0, A1, A2, A3, A4, A5,
        A6, A7, S2, S3, S4, S5, S6, S7,
        S8, S9, S10, S11, T3, T4, T5, T6
    } abi_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: address qualification, optional same-cycle
// write forwarding, and zero/not-busy output for invalid or idle reads.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            run_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] word_i,
    input  logic            busy_i,
    input  logic            fwd_en_i,
    input  logic [AW-1:0]   fwd_addr_i,
    input  logic [XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            busy_o
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic addr_ok;
    logic fwd_hit;

    assign addr_ok = run_i && (addr_i != '0) && ({1'b0, addr_i} < NREGS_W);
    // fwd_en_i is already qualified as a legal write by the top level.
    assign fwd_hit = (BYPASS != 0) && fwd_en_i && (fwd_addr_i == addr_i);

    always_comb begin
        data_o = '0;
        busy_o = 1'b0;
        if (addr_ok) begin
            if (fwd_hit) begin
                data_o = fwd_data_i;
                busy_o = 1'b0;
            end else begin
                data_o = word_i;
                busy_o = busy_i;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, an INIT sweep that zeroes
// the array after reset or clear, and NRD combinational read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  NRD    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output state_e              state_o
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    state_e            state_q;
    logic [AW-1:0]     cnt_q;
    logic [NREGS-1:0]  busy_q;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic run;
    logic wr_ok;
    logic iss_ok;

    assign run     = (state_q == RUN);
    assign wr_ok   = run && wr_en  && (wr_addr  != '0) && ({1'b0, wr_addr}  < NREGS_W);
    assign iss_ok  = run && iss_en && (iss_addr != '0) && ({1'b0, iss_addr} < NREGS_W);
    assign ready   = run;
    assign state_o = state_q;

    // Issue is applied after writeback so a same-cycle new producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    busy_q[cnt_q] <= 1'b0;
                    if (cnt_q == LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                RUN: begin
                    if (wr_ok)  busy_q[wr_addr]  <= 1'b0;
                    if (iss_ok) busy_q[iss_addr] <= 1'b1;
                    if (clear) begin
                        state_q <= INIT;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The data array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        regfile_rd_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_port (
            .run_i      (run),
            .addr_i     (addr),
            .word_i     (regs_q[addr]),
            .busy_i     (busy_q[addr]),
            .fwd_en_i   (wr_ok),
            .fwd_addr_i (wr_addr),
            .fwd_data_i (wr_data),
            .data_o     (rd_data[i*XLEN +: XLEN]),
            .busy_o     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against a behavioural model of
// the register file, busy scoreboard and init sweep.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        ready;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    state_e      state_o;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_run;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!m_run || a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_run || a == 5'd0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_run) begin
            m_regs[m_cnt] = 32'd0;
            m_busy[m_cnt] = 1'b0;
            if (m_cnt == 31) begin
                m_run = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
            if (clear) begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic set_idle();
        clear    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'd0;
        iss_en   = 1'b0;
        iss_addr = 5'd0;
    endtask

    // Called at posedge+1; checks outputs at the following negedge.
    task automatic sample();
        logic [4:0] a;
        #4;
        check("ready", {31'd0, ready}, {31'd0, m_run});
        check("state", 32'(state_o), m_run ? 32'(RUN) : 32'(INIT));
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            check($sformatf("rd_data%0d", p), rd_data[p*32 +: 32], exp_data(a));
            check($sformatf("rd_busy%0d", p), {31'd0, rd_busy[p]}, {31'd0, exp_busy(a)});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 100) begin
            rd_addr = 10'($urandom);
            step();
            cnt++;
        end
        check(tag, cnt, exp_cycles);
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a0);
        rd_addr = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst_n = 1'b0;
        set_idle();
        rd_addr = 10'd0;
        model_reset();
        repeat (3) step();

        rst_n = 1'b1;
        wait_ready("sweep_len", 32);

        // Write A0, read it on both ports, then a write to ZERO.
        wr_en = 1'b1; wr_addr = A0; wr_data = 32'hDEAD_BEEF; set_rd(A0, A0);
        sample(); advance();
        set_idle();
        sample();
        check("a0_port0", rd_data[31:0], 32'hDEAD_BEEF);
        check("a0_port1", rd_data[63:32], 32'hDEAD_BEEF);
        advance();
        wr_en = 1'b1; wr_addr = ZERO; wr_data = 32'h1234; set_rd(ZERO, ZERO);
        step();
        set_idle();
        sample();
        check("zero_rd", rd_data[31:0], 32'd0);
        advance();

        // Issue T1, then write T1 while reading it.
        iss_en = 1'b1; iss_addr = T1; set_rd(T1, T1);
        step();
        set_idle();
        sample();
        check("t1_busy", {31'd0, rd_busy[0]}, 32'd1);
        advance();
        wr_en = 1'b1; wr_addr = T1; wr_data = 32'h55;
        sample();
        check("t1_fwd_data", rd_data[31:0], 32'h55);
        check("t1_fwd_busy", {31'd0, rd_busy[1]}, 32'd0);
        advance();

        // Issue and write S2 together: data lands, busy stays set.
        set_idle();
        iss_en = 1'b1; iss_addr = S2; wr_en = 1'b1; wr_addr = S2; wr_data = 32'h77; set_rd(S2, ZERO);
        step();
        set_idle();
        sample();
        check("s2_data", rd_data[63:32], 32'h77);
        check("s2_busy", {31'd0, rd_busy[1]}, 32'd1);
        advance();

        // Clear after writing SP.
        wr_en = 1'b1; wr_addr = SP; wr_data = 32'h100; set_rd(SP, SP);
        step();
        set_idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
        sample();
        check("clear_ready", {31'd0, ready}, 32'd0);
        advance();
        wait_ready("clear_len", 31);
        set_rd(SP, SP);
        sample();
        check("sp_cleared", rd_data[31:0], 32'd0);
        advance();

        // Reset in the middle of a sweep.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        model_reset();
        sample();
        check("rst_ready", {31'd0, ready}, 32'd0);
        advance();
        step();
        rst_n = 1'b1;
        wait_ready("rst_sweep_len", 32);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] hot;
            hot      = 5'($urandom_range(0, 7));
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = ($urandom_range(0, 1) != 0) ? hot : 5'($urandom);
            wr_data  = $urandom;
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 1) != 0) ? hot : 5'($urandom);
            clear    = ($urandom_range(0, 59) == 0);
            rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 7));
            rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? rd_addr[4:0] : 5'($urandom);
            step();
        end
        set_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, the same-cycle write is forwarded to the read ports.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clear  in  1  request to zero the whole file; sampled in RUN only.
REQ-009 ready  out  1  high when the file accepts writes and issues.
REQ-010 rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-011 rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012 rd_busy  out  NRD  the addressed register has a pending producer.
REQ-013 wr_en  in  1  writeback strobe.
REQ-014 wr_addr  in  AW  writeback destination.
REQ-015 wr_data  in  XLEN  writeback value.
REQ-016 iss_en  in  1  issue strobe; marks the destination busy.
REQ-017 iss_addr  in  AW  issued destination.

Function
REQ-018 SHALL implement FSM states INIT and RUN; ready = (state == RUN).
REQ-019 INIT: each cycle SHALL zero registers[cnt] and busy[cnt], then increment cnt; on cnt == NREGS-1, SHALL go to RUN and set cnt to 0. The sweep SHALL take exactly NREGS cycles.
REQ-020 RUN with clear = 1 SHALL go to INIT with cnt = 0 on the next edge. Any write or issue in that same cycle SHALL still take effect and is then overwritten by the sweep.
REQ-021 In INIT, wr_en and iss_en SHALL be ignored, every rd_data port SHALL read 0 and every rd_busy port SHALL read 0.
REQ-022 In RUN, reads SHALL be combinational: rd_data[i] = registers[rd_addr[i]], and rd_busy[i] = busy[rd_addr[i]].
REQ-023 Address 0 SHALL always read 0 with busy 0; writes and issues to address 0 SHALL be ignored.
REQ-024 Addresses >= NREGS SHALL read 0 with busy 0; writes and issues to them SHALL be ignored.
REQ-025 A write (RUN, wr_en, valid non-zero wr_addr) SHALL update registers[wr_addr] on the rising edge and clear busy[wr_addr].
REQ-026 An issue (RUN, iss_en, valid non-zero iss_addr) SHALL set busy[iss_addr] on the rising edge.
REQ-027 When an issue and a write target the same address in the same cycle, the data SHALL be written and busy SHALL end at 1, because the new producer wins.
REQ-028 With BYPASS = 1 and a valid write whose wr_addr equals rd_addr[i] (non-zero): rd_data[i] SHALL equal wr_data and rd_busy[i] SHALL be 0 in the same cycle.
REQ-029 With BYPASS = 0, reads SHALL return the pre-edge value.
REQ-030 Multiple read ports addressing the same register SHALL each return identical data.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state = INIT, cnt = 0, busy = all 0 and ready = 0, regardless of clk.
REQ-032 The register array SHALL NOT be asynchronously reset; the INIT sweep clears it.
REQ-033 Output values under reset SHALL be: ready 0, rd_data all 0, rd_busy all 0.
REQ-034 Reset asserted mid-sweep or mid-RUN SHALL restart the full NREGS-cycle sweep after deassertion.

Structure
REQ-035 Shared package regfile_pkg SHALL hold the state enum (INIT, RUN) and the ABI alias enum (ZERO, RA, SP, GP, TP, T0-T2, S0FP, S1, A0-A7, S2-S11, T3-T6).
REQ-036 Sub-module regfile_rd_port SHALL be instantiated NRD times (generate). Each instance takes address, array word, busy bit, write-forward inputs and BYPASS, and produces rd_data[i] and rd_busy[i].

Verification
REQ-037 Reset, then count cycles -> ready rises exactly 32 cycles after rst_n deasserts, and all reads return 0 during the sweep.
REQ-038 Write 0xDEADBEEF to A0, then read port 0 = A0 and port 1 = A0 -> both return 0xDEADBEEF. Write 0x1234 to ZERO -> reads return 0.
REQ-039 Issue T1 -> rd_busy = 1 on the next cycle. Write 0x55 to T1 while reading T1 (BYPASS = 1) -> same-cycle rd_data = 0x55 and rd_busy = 0.
REQ-040 Issue and write S2 in the same cycle with 0x77 -> S2 reads 0x77 with busy 1.
REQ-041 Assert clear in RUN after writing SP = 0x100 -> ready falls, and 32 cycles later SP reads 0 and ready = 1.
REQ-042 Assert rst_n low at sweep cycle 10 -> ready stays 0, the sweep restarts, and ready rises 32 cycles after release.
